// File: rtl/sram_ctrl.sv
// sram_ctrl: simplecore 32-bit bus to 1k x 16 async SRAM bridge, two halfword phases with registered strobes
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        req,
  input  logic        we,
  input  logic [8:0]  addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic [9:0]  sram_addr,
  inout  wire  [15:0] sram_data,
  output logic        nCS,
  output logic        nOE,
  output logic        nWE,
  output logic        nLB,
  output logic        nUB
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RECOVER, DONE} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic        hi, we_r, drive;
  logic [3:0]  be_r;
  logic [8:0]  addr_r;
  logic [31:0] wdata_r, rbuf;
  logic [15:0] dout;
  logic        idle, we_s, go_l, go_h;
  logic [3:0]  be_s;
  logic [8:0]  addr_s;
  logic [31:0] wdata_s;
  logic [1:0]  bep, pb;
  logic [15:0] rmask;
  assign sram_data = drive ? dout : 'z;
  // Phase launch sources: live bus inputs on accept, latched copies when chaining from RECOVER
  assign idle    = state == IDLE;
  assign be_s    = idle ? be : be_r;
  assign we_s    = idle ? we : we_r;
  assign addr_s  = idle ? addr : addr_r;
  assign wdata_s = idle ? wdata : wdata_r;
  assign go_l    = idle & |be[1:0];
  assign go_h    = idle ? (~|be[1:0] & |be[3:2]) : (~hi & |be_r[3:2]);
  assign pb      = go_h ? be_s[3:2] : be_s[1:0];
  assign bep     = hi ? be_r[3:2] : be_r[1:0];
  assign rmask   = {{8{bep[1]}}, {8{bep[0]}}};
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state     <= IDLE;
      {nCS, nOE, nWE, nLB, nUB} <= '1;
      drive     <= 1'b0;
      sram_addr <= '0;
      rdata     <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      hi        <= 1'b0;
      cnt       <= '0;
      we_r      <= 1'b0;
      be_r      <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      rbuf      <= '0;
      dout      <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE, RECOVER: if (state == RECOVER || req) begin
          if (idle) begin
            we_r    <= we;
            be_r    <= be;
            addr_r  <= addr;
            wdata_r <= wdata;
            rbuf    <= '0;
            busy    <= 1'b1;
          end
          nWE <= 1'b1;
          if (go_l | go_h) begin
            state     <= SETUP;
            hi        <= go_h;
            sram_addr <= {addr_s, go_h};
            dout      <= go_h ? wdata_s[31:16] : wdata_s[15:0];
            drive     <= we_s;
            nCS       <= 1'b0;
            nOE       <= we_s;
            nLB       <= ~pb[0];
            nUB       <= ~pb[1];
          end else begin
            state <= DONE;
            ready <= 1'b1;
            drive <= 1'b0;
            {nCS, nOE, nLB, nUB} <= '1;
            if (!we_s) rdata <= idle ? '0 : rbuf;
          end
        end
        SETUP: begin
          state <= ACCESS;
          cnt   <= 4'(WAIT_CYCLES - 1);
          nWE   <= ~we_r;
        end
        ACCESS: if (cnt == 0) begin
          state <= RECOVER;
          nOE   <= 1'b1;
          nWE   <= 1'b1;
          if (!we_r && hi) rbuf[31:16] <= sram_data & rmask;
          if (!we_r && !hi) rbuf[15:0] <= sram_data & rmask;
        end else cnt <= cnt - 4'd1;
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
